// File: rtl/decode_pkg.sv
// Shared types for the decode stage: opcode encoding, field placement helper
// and the ID/EX payload carried to execute.
package decode_pkg;

  // Payload fields are sized to these ceilings; the top keeps only the low bits it needs.
  localparam int MAX_W  = 64;
  localparam int MAX_AW = 8;
  localparam int MAX_OW = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_ADDI  = 4'h8,
    OP_LOAD  = 4'h9,
    OP_STORE = 4'hA,
    OP_BR    = 4'hB,
    OP_JMP   = 4'hC
  } opcode_e;

  // LSB of register field idx (0=rd, 1=rs1, 2=rs2); the fields sit back to back below the opcode.
  function automatic int field_lsb(int iw, int ow, int aw, int idx);
    return iw - ow - aw * (idx + 1);
  endfunction

  typedef struct packed {
    logic [MAX_OW-1:0] opcode;
    logic [MAX_AW-1:0] rd;
    logic [MAX_AW-1:0] rs1;
    logic [MAX_AW-1:0] rs2;
    logic [MAX_W-1:0]  rs1_data;
    logic [MAX_W-1:0]  rs2_data;
    logic [MAX_W-1:0]  imm;
    logic [MAX_W-1:0]  pc;
  } idex_t;

endpackage

// File: rtl/pipelined_decode_if.sv
// Fetch-side, writeback and execute-side signals of the decode stage.
interface pipelined_decode_if #(
  parameter int WIDTH            = 24,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int OPCODEWIDTH      = 4,
  parameter int ADDRESSWIDTH     = 4
);
  logic                        inValid;
  logic                        inReady;
  logic [INSTRUCTIONWIDTH-1:0] instruction;
  logic [WIDTH-1:0]            PC;
  logic                        flush;
  logic                        writeEnable;
  logic [ADDRESSWIDTH-1:0]     writeAddress;
  logic [WIDTH-1:0]            dataToSave;
  logic                        outValid;
  logic                        outReady;
  logic [OPCODEWIDTH-1:0]      opcode;
  logic [ADDRESSWIDTH-1:0]     regDestinationAddress;
  logic [ADDRESSWIDTH-1:0]     reg1Address;
  logic [ADDRESSWIDTH-1:0]     reg2Address;
  logic [WIDTH-1:0]            reg1Content;
  logic [WIDTH-1:0]            reg2Content;
  logic [WIDTH-1:0]            inmediate;
  logic [WIDTH-1:0]            outPC;
  logic [15:0]                 stallCount;

  modport slave (
    input  inValid, instruction, PC, flush, writeEnable, writeAddress, dataToSave, outReady,
    output inReady, outValid, opcode, regDestinationAddress, reg1Address, reg2Address,
           reg1Content, reg2Content, inmediate, outPC, stallCount
  );

  modport master (
    output inValid, instruction, PC, flush, writeEnable, writeAddress, dataToSave, outReady,
    input  inReady, outValid, opcode, regDestinationAddress, reg1Address, reg2Address,
           reg1Content, reg2Content, inmediate, outPC, stallCount
  );
endinterface

// File: rtl/pipelined_decode_register_bank.sv
// Register file: two read ports with PC alias and write-through bypass, one write port.
module register_bank #(
  parameter int WIDTH        = 24,
  parameter int ADDRESSWIDTH = 4,
  parameter int REGNUM       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] rd_addr_a,
  input  logic [ADDRESSWIDTH-1:0] rd_addr_b,
  output logic [WIDTH-1:0]        rd_data_a,
  output logic [WIDTH-1:0]        rd_data_b,
  input  logic [WIDTH-1:0]        pc,
  input  logic                    we,
  input  logic [ADDRESSWIDTH-1:0] wa,
  input  logic [WIDTH-1:0]        wd
);
  localparam logic [ADDRESSWIDTH-1:0] PC_IDX = ADDRESSWIDTH'(REGNUM - 1);

  logic [REGNUM-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                         wr_ok;

  // PC alias wins, then same-cycle writeback data, then stored contents.
  function automatic logic [WIDTH-1:0] rd_port(input logic [ADDRESSWIDTH-1:0] a,
                                               input logic [REGNUM-1:0][WIDTH-1:0] m,
                                               input logic [WIDTH-1:0] p);
    if (a == PC_IDX)            return p;
    else if (we && wa == a)     return wd;
    else if (int'(a) < REGNUM)  return m[a];
    else                        return '0;
  endfunction

  assign wr_ok     = we && (wa != PC_IDX) && (int'(wa) < REGNUM);
  assign rd_data_a = rd_port(rd_addr_a, mem_q, pc);
  assign rd_data_b = rd_port(rd_addr_b, mem_q, pc);

  // Next storage contents: one entry updated on a legal write.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wa] = wd;
  end

  // Storage register, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end
endmodule

// File: rtl/pipelined_decode.sv
// Decode stage: field extraction, operand read, immediate extension, ID/EX
// register with valid/ready handshake, flush, and one-bubble load-use stall.
module pipelined_decode
  import decode_pkg::*;
#(
  parameter int WIDTH            = 24,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int OPCODEWIDTH      = 4,
  parameter int ADDRESSWIDTH     = 4,
  parameter int REGNUM           = 16,
  parameter int IMMWIDTH         = 16,
  parameter int SIGNEXT          = 0
) (
  input logic           clock,
  input logic           reset,
  pipelined_decode_if.slave bus
);
  localparam int RD_LSB  = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, ADDRESSWIDTH, 0);
  localparam int RS1_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, ADDRESSWIDTH, 1);
  localparam int RS2_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, ADDRESSWIDTH, 2);

  logic [OPCODEWIDTH-1:0]  op_in;
  logic [ADDRESSWIDTH-1:0] rd_in, rs1_in, rs2_in;
  logic [WIDTH-1:0]        imm_ext, rs1_data, rs2_data;
  logic                    hazard, accept, in_ready;

  idex_t       pl_q, pl_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] stall_q, stall_d;
  logic        unused_pl;

  assign op_in  = bus.instruction[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
  assign rd_in  = bus.instruction[RD_LSB  +: ADDRESSWIDTH];
  assign rs1_in = bus.instruction[RS1_LSB +: ADDRESSWIDTH];
  assign rs2_in = bus.instruction[RS2_LSB +: ADDRESSWIDTH];

  generate
    if (IMMWIDTH >= WIDTH) begin : g_imm_trunc
      assign imm_ext = bus.instruction[WIDTH-1:0];
    end else if (SIGNEXT != 0) begin : g_imm_sext
      assign imm_ext = {{(WIDTH-IMMWIDTH){bus.instruction[IMMWIDTH-1]}}, bus.instruction[IMMWIDTH-1:0]};
    end else begin : g_imm_zext
      assign imm_ext = {{(WIDTH-IMMWIDTH){1'b0}}, bus.instruction[IMMWIDTH-1:0]};
    end
  endgenerate

  register_bank #(
    .WIDTH(WIDTH), .ADDRESSWIDTH(ADDRESSWIDTH), .REGNUM(REGNUM)
  ) u_bank (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_a (rs1_in),
    .rd_addr_b (rs2_in),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data),
    .pc        (bus.PC),
    .we        (bus.writeEnable),
    .wa        (bus.writeAddress),
    .wd        (bus.dataToSave)
  );

  // A load still in ID/EX cannot forward its result to a consumer entering now.
  assign hazard   = out_valid_q
                 && (pl_q.opcode[OPCODEWIDTH-1:0] == OPCODEWIDTH'(OP_LOAD))
                 && ((pl_q.rd[ADDRESSWIDTH-1:0] == rs1_in) || (pl_q.rd[ADDRESSWIDTH-1:0] == rs2_in))
                 && bus.inValid;
  assign in_ready = !bus.flush && !hazard && (!out_valid_q || bus.outReady);
  assign accept   = bus.inValid && in_ready;

  // Next ID/EX state: flush clears, accept loads, drain drops valid, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    pl_d        = pl_q;
    stall_d     = stall_q;
    if (hazard && !bus.flush && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      pl_d        = '0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      pl_d.opcode   = MAX_OW'(op_in);
      pl_d.rd       = MAX_AW'(rd_in);
      pl_d.rs1      = MAX_AW'(rs1_in);
      pl_d.rs2      = MAX_AW'(rs2_in);
      pl_d.rs1_data = MAX_W'(rs1_data);
      pl_d.rs2_data = MAX_W'(rs2_data);
      pl_d.imm      = MAX_W'(imm_ext);
      pl_d.pc       = MAX_W'(bus.PC);
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // ID/EX register, valid flag and stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pl_q        <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pl_q        <= pl_d;
      stall_q     <= stall_d;
    end
  end

  // Payload upper bits beyond the configured widths are never read.
  assign unused_pl = ^pl_q;

  assign bus.inReady               = in_ready;
  assign bus.outValid              = out_valid_q;
  assign bus.opcode                = pl_q.opcode[OPCODEWIDTH-1:0];
  assign bus.regDestinationAddress = pl_q.rd[ADDRESSWIDTH-1:0];
  assign bus.reg1Address           = pl_q.rs1[ADDRESSWIDTH-1:0];
  assign bus.reg2Address           = pl_q.rs2[ADDRESSWIDTH-1:0];
  assign bus.reg1Content           = pl_q.rs1_data[WIDTH-1:0];
  assign bus.reg2Content           = pl_q.rs2_data[WIDTH-1:0];
  assign bus.inmediate             = pl_q.imm[WIDTH-1:0];
  assign bus.outPC                 = pl_q.pc[WIDTH-1:0];
  assign bus.stallCount            = stall_q;
endmodule

// File: tb/tb_pipelined_decode.sv
// Bench for pipelined_decode: a zero-extend and a sign-extend instance share stimulus;
// a reference model of the stage is compared after every edge, plus literal spot checks.
module tb_pipelined_decode;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipelined_decode_if bus0 ();
  pipelined_decode_if bus1 ();

  pipelined_decode #(.SIGNEXT(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  pipelined_decode #(.SIGNEXT(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  assign bus1.inValid      = bus0.inValid;
  assign bus1.instruction  = bus0.instruction;
  assign bus1.PC           = bus0.PC;
  assign bus1.flush        = bus0.flush;
  assign bus1.writeEnable  = bus0.writeEnable;
  assign bus1.writeAddress = bus0.writeAddress;
  assign bus1.dataToSave   = bus0.dataToSave;
  assign bus1.outReady     = bus0.outReady;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [23:0] m_regs [16];
  logic        m_valid;
  logic [3:0]  m_op, m_rd, m_rs1, m_rs2;
  logic [23:0] m_r1, m_r2, m_imm0, m_imm1, m_pc;
  logic [15:0] m_stall;
  logic [3:0]  i_op, i_rd, i_rs1, i_rs2;
  logic [15:0] i_imm;
  logic        m_hazard, m_ready;

  assign i_op  = bus0.instruction[23:20];
  assign i_rd  = bus0.instruction[19:16];
  assign i_rs1 = bus0.instruction[15:12];
  assign i_rs2 = bus0.instruction[11:8];
  assign i_imm = bus0.instruction[15:0];

  function automatic logic [23:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return bus0.PC;
    if (bus0.writeEnable && bus0.writeAddress == a) return bus0.dataToSave;
    return m_regs[a];
  endfunction

  assign m_hazard = m_valid && (m_op == 4'h9) && (m_rd == i_rs1 || m_rd == i_rs2) && bus0.inValid;
  assign m_ready  = !bus0.flush && !m_hazard && (!m_valid || bus0.outReady);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_op <= '0; m_rd <= '0; m_rs1 <= '0; m_rs2 <= '0;
      m_r1 <= '0; m_r2 <= '0; m_imm0 <= '0; m_imm1 <= '0; m_pc <= '0; m_stall <= '0;
      for (int i = 0; i < 16; i++) m_regs[i] <= '0;
    end else begin
      if (bus0.writeEnable && bus0.writeAddress != 4'd15) m_regs[bus0.writeAddress] <= bus0.dataToSave;
      if (m_hazard && !bus0.flush && m_stall != 16'hFFFF) m_stall <= m_stall + 16'd1;
      if (bus0.flush) m_valid <= 1'b0;
      else if (bus0.inValid && m_ready) begin
        m_valid <= 1'b1;
        m_op <= i_op; m_rd <= i_rd; m_rs1 <= i_rs1; m_rs2 <= i_rs2;
        m_r1 <= m_read(i_rs1);
        m_r2 <= m_read(i_rs2);
        m_imm0 <= {8'h00, i_imm};
        m_imm1 <= i_imm[15] ? {8'hFF, i_imm} : {8'h00, i_imm};
        m_pc <= bus0.PC;
      end else if (bus0.outReady) m_valid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic compare();
    check("outValid",  32'(bus0.outValid),   32'(m_valid));
    check("outValid1", 32'(bus1.outValid),   32'(m_valid));
    check("inReady",   32'(bus0.inReady),    32'(m_ready));
    check("stallCnt",  32'(bus0.stallCount), 32'(m_stall));
    if (m_valid) begin
      check("opcode", 32'(bus0.opcode),                32'(m_op));
      check("rd",     32'(bus0.regDestinationAddress), 32'(m_rd));
      check("rs1",    32'(bus0.reg1Address),           32'(m_rs1));
      check("rs2",    32'(bus0.reg2Address),           32'(m_rs2));
      check("r1data", 32'(bus0.reg1Content),           32'(m_r1));
      check("r2data", 32'(bus0.reg2Content),           32'(m_r2));
      check("immZ",   32'(bus0.inmediate),             32'(m_imm0));
      check("immS",   32'(bus1.inmediate),             32'(m_imm1));
      check("outPC",  32'(bus0.outPC),                 32'(m_pc));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic drive(input logic v, input logic [23:0] ins, input logic [23:0] pc,
                       input logic fl, input logic rdy);
    bus0.inValid = v; bus0.instruction = ins; bus0.PC = pc;
    bus0.flush = fl; bus0.outReady = rdy;
  endtask

  task automatic wr(input logic we, input logic [3:0] wa, input logic [23:0] wd);
    bus0.writeEnable = we; bus0.writeAddress = wa; bus0.dataToSave = wd;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drive(1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
    wr(1'b0, 4'h0, 24'h0);
    tick(); tick();
    check("rst_outValid", 32'(bus0.outValid),    32'h0);
    check("rst_stall",    32'(bus0.stallCount),  32'h0);
    check("rst_opcode",   32'(bus0.opcode),      32'h0);
    check("rst_r1data",   32'(bus0.reg1Content), 32'h0);
    reset = 1'b0;

    // fill r1/r2 then decode 131200
    wr(1'b1, 4'h1, 24'h000AAA); tick();
    wr(1'b1, 4'h2, 24'h000BBB); tick();
    wr(1'b0, 4'h0, 24'h0);
    drive(1'b1, 24'h131200, 24'h000100, 1'b0, 1'b1); tick();
    check("dec_opcode", 32'(bus0.opcode),                32'h1);
    check("dec_rd",     32'(bus0.regDestinationAddress), 32'h3);
    check("dec_rs1",    32'(bus0.reg1Address),           32'h1);
    check("dec_rs2",    32'(bus0.reg2Address),           32'h2);
    check("dec_r1",     32'(bus0.reg1Content),           32'h000AAA);
    check("dec_r2",     32'(bus0.reg2Content),           32'h000BBB);
    check("dec_imm",    32'(bus0.inmediate),             32'h001200);

    // write r1 in the accept cycle: bypass delivers new data
    wr(1'b1, 4'h1, 24'h123456); tick();
    wr(1'b0, 4'h0, 24'h0);
    check("bypass_r1", 32'(bus0.reg1Content), 32'h123456);

    // immediate 0x8000 both extensions, then PC alias
    drive(1'b1, 24'h248000, 24'h000000, 1'b0, 1'b1); tick();
    check("imm_zext", 32'(bus0.inmediate), 32'h008000);
    check("imm_sext", 32'(bus1.inmediate), 32'hFF8000);
    drive(1'b1, 24'h24F000, 24'h000040, 1'b0, 1'b1); tick();
    check("pc_alias", 32'(bus0.reg1Content), 32'h000040);

    // load-use: one bubble
    drive(1'b1, 24'h950000, 24'h000200, 1'b0, 1'b1); tick();
    check("load_op", 32'(bus0.opcode), 32'h9);
    drive(1'b1, 24'h105000, 24'h000204, 1'b0, 1'b1); #1;
    check("hz_inReady", 32'(bus0.inReady), 32'h0);
    tick();
    check("hz_bubble", 32'(bus0.outValid),   32'h0);
    check("hz_stall",  32'(bus0.stallCount), 32'h1);
    tick();
    check("hz_issue_v",   32'(bus0.outValid),    32'h1);
    check("hz_issue_rs1", 32'(bus0.reg1Address), 32'h5);

    // backpressure hold for 3 cycles
    drive(1'b1, 24'h361234, 24'h000300, 1'b0, 1'b1); tick();
    drive(1'b1, 24'h371111, 24'h000304, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_valid", 32'(bus0.outValid),  32'h1);
      check("hold_op",    32'(bus0.opcode),    32'h3);
      check("hold_imm",   32'(bus0.inmediate), 32'h001234);
      check("hold_ready", 32'(bus0.inReady),   32'h0);
    end

    // flush with a write in the same cycle; the presented input is dropped
    drive(1'b1, 24'h371111, 24'h000304, 1'b1, 1'b0);
    wr(1'b1, 4'h7, 24'h777777); tick();
    wr(1'b0, 4'h0, 24'h0);
    check("flush_valid", 32'(bus0.outValid), 32'h0);
    drive(1'b0, 24'h0, 24'h0, 1'b0, 1'b1); tick();
    check("flush_noacc", 32'(bus0.outValid), 32'h0);
    drive(1'b1, 24'h107700, 24'h000400, 1'b0, 1'b1); tick();
    check("flush_write", 32'(bus0.reg1Content), 32'h777777);

    // load-use under backpressure: hazard persists while the load is held
    drive(1'b1, 24'h9A0000, 24'h000500, 1'b0, 1'b1); tick();
    drive(1'b1, 24'h10A000, 24'h000504, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 24'h10A000, 24'h000504, 1'b0, 1'b1); tick();
    check("hz2_bubble", 32'(bus0.outValid), 32'h0);
    tick();
    check("hz2_issue", 32'(bus0.reg1Address), 32'hA);
    check("hz2_stall", 32'(bus0.stallCount),  32'h4);

    // asynchronous reset between edges
    drive(1'b1, 24'h131200, 24'h000600, 1'b0, 1'b1); tick();
    drive(1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid",  32'(bus0.outValid),   32'h0);
    check("arst_stall",  32'(bus0.stallCount), 32'h0);
    check("arst_opcode", 32'(bus0.opcode),     32'h0);
    tick();
    reset = 1'b0;
    drive(1'b1, 24'h101000, 24'h000700, 1'b0, 1'b1); tick();
    check("arst_first", 32'(bus0.outValid),    32'h1);
    check("arst_r1",    32'(bus0.reg1Content), 32'h0);
    drive(1'b0, 24'h0, 24'h0, 1'b0, 1'b1); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_decode.md
# pipelined_decode

Parametrised instruction-decode stage with an integrated register bank, ID/EX pipeline register, valid/ready handshakes, flush, and load-use stall. It sits between fetch and execute in the processor pipeline. It performs field extraction, operand read with same-cycle writeback bypass, and immediate extension. It registers all results for the execute stage and inserts one bubble when an instruction depends on a load still in the ID/EX register.

## Interface
- WIDTH, 24: datapath width.
- INSTRUCTIONWIDTH, 24: instruction width.
- OPCODEWIDTH, 4: opcode field width.
- ADDRESSWIDTH, 4: register address width.
- REGNUM, 16: register count (≤ 2^ADDRESSWIDTH). Index REGNUM-1 is the PC alias.
- IMMWIDTH, 16: immediate field width.
- SIGNEXT, 0: 1 = sign-extend immediate, 0 = zero-extend.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- inValid / inReady  in / out  1  upstream handshake.
- instruction  in  INSTRUCTIONWIDTH  instruction word.
- PC  in  WIDTH  PC of instruction.
- flush  in  1  discard ID/EX contents.
- writeEnable  in  1  writeback strobe.
- writeAddress  in  ADDRESSWIDTH  writeback register.
- dataToSave  in  WIDTH  writeback data.
- outValid / outReady  out / in  1  downstream handshake.
- opcode  out  OPCODEWIDTH  registered.
- regDestinationAddress, reg1Address, reg2Address  out  ADDRESSWIDTH  registered.
- reg1Content, reg2Content, inmediate, outPC  out  WIDTH  registered.
- stallCount  out  16  saturating count of load-use stall cycles.

## Operation
- Fields: opcode = instruction[IW-1 -: OW]; rd = next AW bits below opcode; rs1 = next AW bits; rs2 = next AW bits; imm = instruction[IMMWIDTH-1:0]. With default parameters this gives opcode [23:20], rd [19:16], rs1 [15:12], rs2 [11:8], imm [15:0].
- Immediate: extended to WIDTH per SIGNEXT. Upper bits are 0 when SIGNEXT=0. If IMMWIDTH ≥ WIDTH, the low WIDTH bits are used.
- Operand read priority:
  1. Address REGNUM-1 returns PC.
  2. Otherwise, if writeEnable and writeAddress matches, return dataToSave (bypass).
  3. Otherwise, return the bank contents.
- Writes: bank written on the rising edge when writeEnable=1. Writes to REGNUM-1 or to addresses ≥ REGNUM are ignored. Writes are independent of flush and stalls.
- Load-use hazard: asserted when all of the following hold:
  - outValid=1;
  - opcode in ID/EX is OP_LOAD;
  - ID/EX regDestinationAddress equals the incoming rs1 or rs2;
  - inValid=1.
- Handshake: inReady = !flush && !hazard && (!outValid || outReady).
  - Accept: when inValid && inReady, the ID/EX register loads and outValid becomes 1.
  - Drain without accept: if outReady && !accept, outValid becomes 0.
  - Hold: if outValid && !outReady, all outputs hold.
- Flush has the highest priority: on the next edge outValid=0, and no input is accepted in that cycle.
- stallCount increments on each cycle where hazard && !flush, and saturates at 0xFFFF.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Bypass is combinational in the read cycle. A write and an accept on the same edge deliver the new data.
- A load-use hazard costs exactly 1 bubble cycle. It is longer if outReady=0, because the hazard persists until the load leaves ID/EX.
- Reset (asynchronous): outValid=0, all registered outputs 0, all bank registers 0, stallCount=0. Reset asserted mid-operation drops the in-flight instruction. The first accept can occur on the first edge after release.
- Simultaneous flush and writeEnable: the write is performed and the ID/EX register is cleared.

## Structure
- Package decode_pkg holds:
  - the opcode enum, including OP_LOAD = 4'h9;
  - a field-offset function of the parameters;
  - the ID/EX payload struct.
- Sub-module register_bank holds the REGNUM×WIDTH storage, two read ports, one write port, the write-through bypass and the PC alias. The top level holds the handshake, hazard logic, pipeline register and counter.

## Test plan
- Write 0x000AAA to r1 and 0x000BBB to r2, then present 24'h131200 → outputs opcode=1, rd=3, rs1=1, rs2=2, reg1Content=0x000AAA, reg2Content=0x000BBB, inmediate=0x001200, one cycle after accept.
- writeEnable to r1 with 0x123456 in the same cycle as accepting 24'h131200 → reg1Content=0x123456.
- SIGNEXT=1 with imm 0x8000 → inmediate=0xFF8000. With SIGNEXT=0 → 0x008000. Reading rs1=15 with PC=0x000040 → reg1Content=0x000040.
- Accept load 24'h950000 (rd=5), then 24'h105000 (rs1=5) with outReady=1 → inReady=0 for 1 cycle, 1 bubble (outValid=0) on the outputs, stallCount=1, dependent instruction issued next.
- outReady=0 for 3 cycles with an instruction held → outputs stable, inReady=0. Then flush=1 → outValid=0 next cycle and the input presented during flush is not accepted.
- Assert reset mid-stream, asynchronously between edges → outValid=0 immediately, register r1 reads 0 afterwards, stallCount=0.
